// File: rtl/instruction_fetch_ctrl.sv
// instruction_fetch_ctrl
// Sequencer for a 64-entry instruction buffer with combinational read.
// Owns the program counter (driven out as ins_addr).
// Issues each fetched word to the decoder over a valid/ready handshake.
// Fetch stops on a HALT word, after issuing PROG_LAST, or on abort.
// Optional feature: define IFETCH_LOOP_EN for single-level hardware loops.
// LOOP words are consumed in FETCH and never issued. The body T..LOOP-1
// then runs N+1 times.
module instruction_fetch_ctrl #(
  parameter int unsigned AW        = 6,
  parameter int unsigned IW        = 51,
  parameter int unsigned PROG_LAST = 63,
  parameter logic [3:0]  OP_HALT   = 4'hF
`ifdef IFETCH_LOOP_EN
  , parameter logic [3:0] OP_LOOP  = 4'hE
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] start_addr,
  output logic [AW-1:0] ins_addr,
  input  logic [IW-1:0] ins_data,
  output logic [IW-1:0] out_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST = AW'(PROG_LAST);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} state_e;

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [IW-1:0] out_instr_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          done_q;

  logic [3:0]    opcode;
  logic          at_last;
  logic          xfer;

  assign opcode  = ins_data[IW-1 -: 4];
  assign at_last = (pc_q == LAST);
  assign xfer    = out_valid_q & out_ready;

`ifdef IFETCH_LOOP_EN
  logic [AW-1:0] loop_cnt_q;
  logic [AW-1:0] loop_pc_q;
  logic          loop_act_q;
  logic [AW-1:0] loop_n;
  logic [AW-1:0] loop_t;
  logic          same_loop;
  logic          loop_first;
  logic          loop_again;

  assign loop_n     = ins_data[2*AW-1:AW];
  assign loop_t     = ins_data[AW-1:0];
  // Only the LOOP word that opened the active loop may re-jump; others are NOPs.
  assign same_loop  = loop_act_q && (pc_q == loop_pc_q);
  assign loop_first = !loop_act_q && (loop_n != '0);
  assign loop_again = same_loop && (loop_cnt_q != AW'(1));
`endif

  // Fetch/issue FSM with all outputs registered; abort overrides every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      out_instr_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef IFETCH_LOOP_EN
      loop_cnt_q  <= '0;
      loop_pc_q   <= '0;
      loop_act_q  <= 1'b0;
`endif
    end else if (abort) begin
      // pc is deliberately held so the abort point remains visible on ins_addr.
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef IFETCH_LOOP_EN
      loop_cnt_q  <= '0;
      loop_act_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout so every branch reads the
      // pre-edge values of pc_q/state_q regardless of statement order.
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            pc_q    <= start_addr;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
`ifdef IFETCH_LOOP_EN
            // A loop left open by the previous program must not leak into this one.
            loop_act_q <= 1'b0;
            loop_cnt_q <= '0;
`endif
          end
        end
        S_FETCH: begin
          if (opcode == OP_HALT) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
`ifdef IFETCH_LOOP_EN
          end else if (opcode == OP_LOOP) begin
            if (loop_first) begin
              loop_act_q <= 1'b1;
              loop_cnt_q <= loop_n;
              loop_pc_q  <= pc_q;
              pc_q       <= loop_t;
            end else if (loop_again) begin
              loop_cnt_q <= loop_cnt_q - AW'(1);
              pc_q       <= loop_t;
            end else begin
              if (same_loop) loop_act_q <= 1'b0;
              if (at_last) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                pc_q <= pc_q + AW'(1);
              end
            end
`endif
          end else begin
            out_instr_q <= ins_data;
            out_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (xfer) begin
            out_valid_q <= 1'b0;
            if (at_last) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              pc_q    <= pc_q + AW'(1);
              state_q <= S_FETCH;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ins_addr  = pc_q;
  assign out_instr = out_instr_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Testbench for instruction_fetch_ctrl: cycle table for the basic run,
// hand-written corner sequences, and random programs checked against a
// program-interpreter reference model.
module tb_instruction_fetch_ctrl;

  localparam int AW = 6;
  localparam int IW = 51;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] ins_addr;
  logic [IW-1:0] ins_data;
  logic [IW-1:0] out_instr;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  logic [IW-1:0] mem [64];
  logic [IW-1:0] exp_q[$];
  logic [IW-1:0] got_q[$];

  int checks = 0;
  int errors = 0;

  instruction_fetch_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .start_addr (start_addr),
    .ins_addr   (ins_addr),
    .ins_data   (ins_data),
    .out_instr  (out_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  assign ins_data = mem[ins_addr];

  always #5 clk = ~clk;

  typedef struct {
    logic          start;
    logic [AW-1:0] sa;
    logic          ready;
    logic          exp_valid;
    logic [IW-1:0] exp_instr;
    logic          exp_busy;
    logic          exp_done;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vt[9];

  task automatic check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] word(input logic [3:0] op, input logic [46:0] payload);
    return {op, payload};
  endfunction

  function automatic vec_t mkv(input logic st, input logic ev, input logic [IW-1:0] ei,
                               input logic eb, input logic ed, input logic [AW-1:0] ea);
    vec_t v;
    v.start = st; v.sa = '0; v.ready = 1'b1;
    v.exp_valid = ev; v.exp_instr = ei; v.exp_busy = eb; v.exp_done = ed; v.exp_addr = ea;
    return v;
  endfunction

  // Reference: interpret the program from sa and list the words that must be issued.
  task automatic model_run(input logic [AW-1:0] sa);
    int pc = sa;
    int cnt = 0;
    int lp = 0;
    bit act = 0;
    logic [IW-1:0] w;
    exp_q.delete();
    forever begin
      w = mem[pc];
      if (w[50:47] == 4'hF) break;
`ifdef IFETCH_LOOP_EN
      if (w[50:47] == 4'hE) begin
        int n = int'(w[11:6]);
        int t = int'(w[5:0]);
        if (!act && n != 0) begin
          act = 1; cnt = n; lp = pc; pc = t;
          continue;
        end
        if (act && pc == lp) begin
          if (cnt != 1) begin cnt--; pc = t; continue; end
          act = 0;
        end
        if (pc == 63) break;
        pc++;
        continue;
      end
`endif
      exp_q.push_back(w);
      if (pc == 63) break;
      pc++;
    end
  endtask

  // Start a run and record every handshake transfer until done (bounded).
  task automatic run_program(input logic [AW-1:0] sa, input bit rand_ready);
    int cyc = 0;
    got_q.delete();
    start = 1'b1; start_addr = sa; out_ready = 1'b1;
    step();
    start = 1'b0;
    while (!done && cyc < 20000) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) got_q.push_back(out_instr);
      step();
      cyc++;
    end
    check("run_reaches_done", done, 1);
  endtask

  task automatic compare_queues(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({name, "_word"}, got_q[i], exp_q[i]);
  endtask

  logic [IW-1:0] wa, wb, wc, w5, w62, w63, w_halt, w_loop;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0; start_addr = '0;
    for (int i = 0; i < 64; i++) mem[i] = word(4'(i % 13), 47'(i * 32'h1357 + 7));
    wa     = word(4'h1, 47'h0AAA_0000_1111);
    wb     = word(4'h2, 47'h0BBB_0000_2222);
    wc     = word(4'h3, 47'h0CCC_0000_3333);
    w5     = word(4'h5, 47'h0555_5555_5555);
    w62    = word(4'h6, 47'h0062_0062_0062);
    w63    = word(4'h7, 47'h0063_0063_0063);
    w_halt = word(4'hF, 47'h0);
    w_loop = word(4'hE, {35'h0, 6'd2, 6'd0});
    mem[0] = wa; mem[1] = wb; mem[2] = wc; mem[3] = w_halt;
    mem[5] = w5; mem[62] = w62; mem[63] = w63;

    // Reset values while rst_n is low
    #2;
    check("rst_addr", ins_addr, 0);
    check("rst_valid", out_valid, 0);
    check("rst_instr", out_instr, 0);
    #10 rst_n = 1'b1;

    // 1. Idle after reset for 10 cycles
    for (int k = 0; k < 10; k++) begin
      step();
      check("idle_addr", ins_addr, 0);
      check("idle_valid", out_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
    end

    // 2. Basic run as a cycle table: words 0..2 two cycles apart, HALT at 3
    vt[0] = mkv(1, 0, '0, 1, 0, 0);
    vt[1] = mkv(0, 1, wa, 1, 0, 0);
    vt[2] = mkv(0, 0, '0, 1, 0, 1);
    vt[3] = mkv(0, 1, wb, 1, 0, 1);
    vt[4] = mkv(0, 0, '0, 1, 0, 2);
    vt[5] = mkv(0, 1, wc, 1, 0, 2);
    vt[6] = mkv(0, 0, '0, 1, 0, 3);
    vt[7] = mkv(0, 0, '0, 0, 1, 3);
    vt[8] = mkv(0, 0, '0, 0, 1, 3);
    for (int i = 0; i < 9; i++) begin
      start = vt[i].start; start_addr = vt[i].sa; out_ready = vt[i].ready;
      step();
      check($sformatf("tbl%0d_valid", i), out_valid, vt[i].exp_valid);
      check($sformatf("tbl%0d_busy", i), busy, vt[i].exp_busy);
      check($sformatf("tbl%0d_done", i), done, vt[i].exp_done);
      check($sformatf("tbl%0d_addr", i), ins_addr, vt[i].exp_addr);
      if (vt[i].exp_valid) check($sformatf("tbl%0d_instr", i), out_instr, vt[i].exp_instr);
    end
    start = 1'b0;

    // 3. Backpressure on word 1, with an ignored start while busy
    start = 1'b1; start_addr = 0; out_ready = 1'b0;
    step();
    start = 1'b0;
    step();
    check("bp_w0", out_instr, wa);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      start = (k == 2); start_addr = 40;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_instr", out_instr, wb);
      check("bp_hold_addr", ins_addr, 1);
      step();
    end
    start = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_after_addr", ins_addr, 2);
    check("bp_after_valid", out_valid, 0);
    out_ready = 1'b0;
    step();
    check("bp_next_instr", out_instr, wc);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // 4. End of program: 62, 63 issued, then DONE without wrapping
    start = 1'b1; start_addr = 62; out_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    check("eop_w62", out_instr, w62);
    step();
    check("eop_addr63", ins_addr, 63);
    step();
    check("eop_w63", out_instr, w63);
    check("eop_valid63", out_valid, 1);
    step();
    check("eop_done", done, 1);
    check("eop_busy", busy, 0);
    check("eop_valid", out_valid, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("eop_no_wrap", ins_addr, 63);
    end

    // 5. Abort while word 1 is offered, then restart at 5
    start = 1'b1; start_addr = 0; out_ready = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    check("ab_w1_valid", out_valid, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_valid", out_valid, 0);
    check("ab_done", done, 0);
    check("ab_busy", busy, 0);
    check("ab_pc_held", ins_addr, 1);
    start = 1'b1; start_addr = 5;
    step();
    start = 1'b0;
    check("ab_restart_addr", ins_addr, 5);
    check("ab_restart_busy", busy, 1);
    step();
    check("ab_restart_w5", out_instr, w5);
    abort = 1'b1;
    step();
    // Simultaneous start and abort: abort wins
    start = 1'b1; start_addr = 9;
    step();
    start = 1'b0; abort = 1'b0;
    check("sa_busy", busy, 0);
    check("sa_addr", ins_addr, 5);

    // Asynchronous reset in the middle of ISSUE
    start = 1'b1; start_addr = 0; out_ready = 1'b0;
    step();
    start = 1'b0;
    step();
    check("rm_valid_before", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rm_valid", out_valid, 0);
    check("rm_addr", ins_addr, 0);
    check("rm_busy", busy, 0);
    #2 rst_n = 1'b1;
    step();

    // 6. Loop program: 0=A 1=B 2=LOOP(N=2,T=0) 3=HALT
    mem[2] = w_loop;
    exp_q.delete();
`ifdef IFETCH_LOOP_EN
    for (int k = 0; k < 3; k++) begin exp_q.push_back(wa); exp_q.push_back(wb); end
`else
    exp_q.push_back(wa); exp_q.push_back(wb); exp_q.push_back(w_loop);
`endif
    run_program(0, 1'b0);
    compare_queues("loop");

    // Random programs against the reference model
    for (int r = 0; r < 8; r++) begin
      logic [AW-1:0] sa;
      for (int i = 0; i < 64; i++) begin
        int sel = $urandom_range(0, 99);
        if (sel < 3)
          mem[i] = w_halt;
        else if (sel < 9)
          mem[i] = word(4'hE, {35'($urandom), 6'($urandom_range(0, 3)), 6'($urandom_range(0, 63))});
        else
          mem[i] = word(4'($urandom_range(0, 13)), {15'($urandom), 32'($urandom)});
      end
      sa = 6'($urandom_range(0, 63));
      model_run(sa);
      run_program(sa, 1'b1);
      compare_queues($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
